led_sequence_ctrl: RTL and testbench
====================================

Name: led_sequence_ctrl

Overview:
Programmable sequencer that drives the one-hot LED select bus of the heartbeat light board. It replaces the fixed free-running rotation with several selectable patterns, a programmable step period, a bounded or endless step count, pause/resume and abort. Upstream control logic configures it through a valid/ready handshake. Downstream LED drivers consume led_select directly.

Parameters:
N_LED, 8, number of LEDs; fixed at 8 for this board, so pos is 3 bits.
DIV_W, 16, width of the step-period divider.
DEFAULT_DIV, 600, divider value loaded at reset.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
cfg_valid  input  1  configuration request
cfg_ready  output  1  high only in IDLE; a config is accepted when cfg_valid && cfg_ready
cfg_mode  input  2  0 rotate-left, 1 rotate-right, 2 ping-pong, 3 blink-all
cfg_div  input  DIV_W  step period in clk cycles; 0 is treated as 1
cfg_steps  input  8  number of steps to run; 0 means endless
run  input  1  1 = advance, 0 = pause
stop  input  1  abort the current sequence
busy  output  1  high in RUN and HOLD
done  output  1  one-cycle pulse after the final step
step_tick  output  1  one-cycle pulse in the cycle following each led_select update
pos  output  3  index of the lit LED; 0 in blink-all mode
led_select  output  N_LED  LED enable pattern

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, led_select=8'b0000_0001, pos=0, cfg_ready=1, busy=0, done=0, step_tick=0.
  - Divider counter=0, step counter=0, div_reg=DEFAULT_DIV, mode_reg=0, steps_reg=0, ping-pong direction=up.
  - Reset mid-sequence takes effect immediately.
- States are IDLE, RUN, HOLD and DONE. All outputs are registered.
- IDLE:
  - On a cfg handshake, latch mode, div (0→1) and steps.
  - Clear the divider counter and the step counter; set direction=up.
  - Load the start pattern: modes 0 and 2 load 0x01/pos 0, mode 1 loads 0x80/pos 7, mode 3 loads 0x00/pos 0.
  - Go to RUN.
  - cfg_valid while not in IDLE is ignored, and config fields are not sampled.
- RUN:
  - If stop=1, go to IDLE with no done and no step; led_select and pos are held. stop has priority over run and over any step due that cycle.
  - Else if run=0, go to HOLD. The counter is not incremented and no step occurs, even if the counter is at div-1.
  - Else, if counter==div_reg-1: step, counter←0. Otherwise counter←counter+1.
  - Step period is exactly div_reg cycles. With run held high, the first step lands on the div_reg-th rising edge after the accepting edge.
- Step action:
  - Update led_select/pos per mode.
  - step_tick=1 for the following cycle.
  - If steps_reg≠0, increment the step counter. When it reaches steps_reg, go to DONE on the same edge.
- Mode rules:
  - Mode 0: rotate left with 7→0 wrap; pos+1 mod 8.
  - Mode 1: rotate right with 0→7 wrap; pos-1 mod 8.
  - Mode 2 (ping-pong): move one position in the current direction. On reaching pos 7 the direction flips to down; on reaching 0 it flips to up. Sequence is 0,1,…,7,6,…,1,0,1… (period 14 steps; the end LEDs are never repeated back to back).
  - Mode 3: led_select toggles 0x00↔0xFF; pos stays 0.
- HOLD:
  - Counter, pattern, direction and step count are frozen.
  - run=1 returns to RUN and resumes from the frozen counter value.
  - stop=1 goes to IDLE; stop wins if run is also high.
- DONE: done=1 and busy=0 for one cycle, then IDLE. led_select keeps the final pattern.
- With steps_reg=0, the sequence runs until stop; the step counter does not increment.

Test Plan:
1. Assert rst mid-RUN → led_select=0x01, pos=0, cfg_ready=1, busy=0 immediately; after release, a new config is accepted.
2. mode 0, div=4, steps=3, run=1, accepted at edge k → led_select 0x02/0x04/0x08 at edges k+4/k+8/k+12; done=1 in the cycle after k+12; cfg_ready=1 after k+13.
3. mode 2, div=1, steps=16 → pos sequence 1,2,3,4,5,6,7,6,5,4,3,2,1,0,1,2, then done pulse.
4. mode 1, div=5, steps=0; drop run for 7 cycles when counter=3 → no led change during the pause; the next step comes exactly 2 run-cycles after resume; the sequence continues endlessly with wrap 0x01→0x80.
5. mode 3, div=2, steps=0; assert stop in the same cycle a step is due → led_select is unchanged, no step_tick, no done; state goes to IDLE.
6. cfg_div=0, mode 0, steps=2 → one step per cycle and done after 2 cycles; a cfg_valid pulse while busy does not change mode_reg or the pattern.

Source files
------------

// File: rtl/led_sequence_ctrl.sv
// Programmable one-hot LED sequencer for the heartbeat light board.
// Config is taken over a valid/ready handshake in IDLE; every output is registered.
module led_sequence_ctrl #(
    parameter int N_LED       = 8,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 600
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_mode,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [7:0]       cfg_steps,
    input  logic             run,
    input  logic             stop,
    output logic             busy,
    output logic             done,
    output logic             step_tick,
    output logic [2:0]       pos,
    output logic [N_LED-1:0] led_select
);

    // state | meaning
    // IDLE  | waiting for config, cfg_ready high
    // RUN   | dividing and stepping     HOLD | paused, everything frozen
    // DONE  | one-cycle done pulse after the final step
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [N_LED-1:0]   r_led,      w_led_nxt,      w_step_led;
    logic [2:0]         r_pos,      w_pos_nxt,      w_step_pos;
    logic               r_dir_up,   w_dir_nxt,      w_step_dir;
    logic [DIV_W-1:0]   r_div_cnt,  w_div_cnt_nxt;
    logic [DIV_W-1:0]   r_div,      w_div_nxt;
    logic [1:0]         r_mode,     w_mode_nxt;
    logic [7:0]         r_steps,    w_steps_nxt;
    logic [7:0]         r_step_cnt, w_step_cnt_nxt;
    logic               r_tick,     w_tick_nxt;
    logic               r_cfg_ready, r_busy, r_done;
    logic               w_accept, w_step, w_last_step;

    assign w_accept    = cfg_valid && (r_state == S_IDLE);
    assign w_step      = (r_state == S_RUN) && !stop && run && (r_div_cnt == r_div - DIV_W'(1));
    assign w_last_step = w_step && (r_steps != 8'd0) && (r_step_cnt + 8'd1 == r_steps);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_RUN;
            S_RUN: begin
                if (stop)             w_state_nxt = S_IDLE;
                else if (!run)        w_state_nxt = S_HOLD;
                else if (w_last_step) w_state_nxt = S_DONE;
            end
            S_HOLD: begin
                if (stop)     w_state_nxt = S_IDLE;
                else if (run) w_state_nxt = S_RUN;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Ping-pong flips direction on arrival at an end so end LEDs are never doubled.
    always_comb begin
        w_step_led = r_led;
        w_step_pos = r_pos;
        w_step_dir = r_dir_up;
        case (r_mode)
            2'd0: begin
                w_step_led = {r_led[N_LED-2:0], r_led[N_LED-1]};
                w_step_pos = r_pos + 3'd1;
            end
            2'd1: begin
                w_step_led = {r_led[0], r_led[N_LED-1:1]};
                w_step_pos = r_pos - 3'd1;
            end
            2'd2: begin
                if (r_dir_up) begin
                    w_step_pos = r_pos + 3'd1;
                    if (r_pos == 3'd6) w_step_dir = 1'b0;
                end else begin
                    w_step_pos = r_pos - 3'd1;
                    if (r_pos == 3'd1) w_step_dir = 1'b1;
                end
                w_step_led = N_LED'(1) << w_step_pos;
            end
            default: begin
                w_step_led = ~r_led;
                w_step_pos = 3'd0;
            end
        endcase
    end

    always_comb begin
        w_led_nxt      = r_led;
        w_pos_nxt      = r_pos;
        w_dir_nxt      = r_dir_up;
        w_div_cnt_nxt  = r_div_cnt;
        w_div_nxt      = r_div;
        w_mode_nxt     = r_mode;
        w_steps_nxt    = r_steps;
        w_step_cnt_nxt = r_step_cnt;
        w_tick_nxt     = 1'b0;
        if (w_accept) begin
            w_mode_nxt     = cfg_mode;
            w_div_nxt      = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
            w_steps_nxt    = cfg_steps;
            w_div_cnt_nxt  = '0;
            w_step_cnt_nxt = 8'd0;
            w_dir_nxt      = 1'b1;
            case (cfg_mode)
                2'd1: begin
                    w_led_nxt = {1'b1, {(N_LED-1){1'b0}}};
                    w_pos_nxt = 3'd7;
                end
                2'd3: begin
                    w_led_nxt = '0;
                    w_pos_nxt = 3'd0;
                end
                default: begin
                    w_led_nxt = N_LED'(1);
                    w_pos_nxt = 3'd0;
                end
            endcase
        end else if (w_step) begin
            w_div_cnt_nxt = '0;
            w_led_nxt     = w_step_led;
            w_pos_nxt     = w_step_pos;
            w_dir_nxt     = w_step_dir;
            w_tick_nxt    = 1'b1;
            if (r_steps != 8'd0) w_step_cnt_nxt = r_step_cnt + 8'd1;
        end else if ((r_state == S_RUN) && !stop && run) begin
            w_div_cnt_nxt = r_div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led       <= N_LED'(1);
            r_pos       <= 3'd0;
            r_dir_up    <= 1'b1;
            r_div_cnt   <= '0;
            r_div       <= DIV_W'(DEFAULT_DIV);
            r_mode      <= 2'd0;
            r_steps     <= 8'd0;
            r_step_cnt  <= 8'd0;
            r_tick      <= 1'b0;
            r_cfg_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_led       <= w_led_nxt;
            r_pos       <= w_pos_nxt;
            r_dir_up    <= w_dir_nxt;
            r_div_cnt   <= w_div_cnt_nxt;
            r_div       <= w_div_nxt;
            r_mode      <= w_mode_nxt;
            r_steps     <= w_steps_nxt;
            r_step_cnt  <= w_step_cnt_nxt;
            r_tick      <= w_tick_nxt;
            r_cfg_ready <= (w_state_nxt == S_IDLE);
            r_busy      <= (w_state_nxt == S_RUN) || (w_state_nxt == S_HOLD);
            r_done      <= (w_state_nxt == S_DONE);
        end
    end

    assign led_select = r_led;
    assign pos        = r_pos;
    assign step_tick  = r_tick;
    assign cfg_ready  = r_cfg_ready;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_led_sequence_ctrl.sv
// Directed bench for led_sequence_ctrl with hand-computed expected values.
module tb_led_sequence_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_mode;
    logic [15:0] cfg_div;
    logic [7:0]  cfg_steps;
    logic        run;
    logic        stop;
    logic        busy;
    logic        done;
    logic        step_tick;
    logic [2:0]  pos;
    logic [7:0]  led_select;

    int checks   = 0;
    int failures = 0;

    led_sequence_ctrl #(.N_LED(8), .DIV_W(16), .DEFAULT_DIV(600)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_mode   (cfg_mode),
        .cfg_div    (cfg_div),
        .cfg_steps  (cfg_steps),
        .run        (run),
        .stop       (stop),
        .busy       (busy),
        .done       (done),
        .step_tick  (step_tick),
        .pos        (pos),
        .led_select (led_select)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [1:0] m, input logic [15:0] d, input logic [7:0] s);
        cfg_mode  = m;
        cfg_div   = d;
        cfg_steps = s;
        cfg_valid = 1'b1;
        tick(1);
        cfg_valid = 1'b0;
    endtask

    logic [2:0] pp_pos [16] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6,
                                3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2};
    logic [7:0] rr_led [8]  = '{8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80, 8'h40};
    logic [2:0] rr_pos [8]  = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6};

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_mode = 2'd0; cfg_div = 16'd0;
        cfg_steps = 8'd0; run = 1'b0; stop = 1'b0;
        tick(2);
        chk("rst_led",   led_select, 8'h01);
        chk("rst_pos",   pos,        3'd0);
        chk("rst_ready", cfg_ready,  1'b1);
        chk("rst_busy",  busy,       1'b0);
        chk("rst_done",  done,       1'b0);
        chk("rst_tick",  step_tick,  1'b0);
        rst = 1'b0;
        run = 1'b1;
        tick(1);

        // mode 0, div 4, steps 3: steps on edges k+4, k+8, k+12
        cfg(2'd0, 16'd4, 8'd3);
        chk("m0_busy",    busy,       1'b1);
        chk("m0_ready",   cfg_ready,  1'b0);
        chk("m0_start",   led_select, 8'h01);
        tick(3);
        chk("m0_k3_led",  led_select, 8'h01);
        chk("m0_k3_tick", step_tick,  1'b0);
        tick(1);
        chk("m0_k4_led",  led_select, 8'h02);
        chk("m0_k4_pos",  pos,        3'd1);
        chk("m0_k4_tick", step_tick,  1'b1);
        tick(1);
        chk("m0_k5_tick", step_tick,  1'b0);
        tick(3);
        chk("m0_k8_led",  led_select, 8'h04);
        tick(4);
        chk("m0_k12_led",  led_select, 8'h08);
        chk("m0_k12_pos",  pos,        3'd3);
        chk("m0_k12_done", done,       1'b1);
        chk("m0_k12_busy", busy,       1'b0);
        chk("m0_k12_rdy",  cfg_ready,  1'b0);
        tick(1);
        chk("m0_k13_done", done,       1'b0);
        chk("m0_k13_rdy",  cfg_ready,  1'b1);
        chk("m0_k13_led",  led_select, 8'h08);

        // reset asserted mid-RUN acts immediately
        cfg(2'd0, 16'd4, 8'd0);
        tick(6);
        chk("r_pre_led", led_select, 8'h02);
        rst = 1'b1;
        #2;
        chk("r_led",   led_select, 8'h01);
        chk("r_pos",   pos,        3'd0);
        chk("r_ready", cfg_ready,  1'b1);
        chk("r_busy",  busy,       1'b0);
        tick(1);
        rst = 1'b0;
        cfg(2'd1, 16'd1, 8'd1);
        chk("r_cfg_busy", busy,       1'b1);
        chk("r_cfg_led",  led_select, 8'h80);
        chk("r_cfg_pos",  pos,        3'd7);
        tick(1);
        chk("r_step_led",  led_select, 8'h40);
        chk("r_step_pos",  pos,        3'd6);
        chk("r_step_done", done,       1'b1);
        tick(1);
        chk("r_end_rdy", cfg_ready, 1'b1);

        // mode 2 ping-pong, div 1, 16 steps
        cfg(2'd2, 16'd1, 8'd16);
        chk("pp_start", pos, 3'd0);
        for (int i = 0; i < 16; i++) begin
            tick(1);
            chk($sformatf("pp_pos%0d", i), pos, pp_pos[i]);
            chk($sformatf("pp_led%0d", i), led_select, 8'(1) << pp_pos[i]);
            chk($sformatf("pp_done%0d", i), done, (i == 15) ? 1'b1 : 1'b0);
        end
        tick(1);
        chk("pp_idle", cfg_ready, 1'b1);

        // mode 1, div 5, endless; pause when divider counter is 3
        cfg(2'd1, 16'd5, 8'd0);
        tick(3);
        run = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick(1);
            chk($sformatf("hold_led%0d", i), led_select, 8'h80);
            chk($sformatf("hold_tick%0d", i), step_tick, 1'b0);
        end
        chk("hold_busy", busy, 1'b1);
        run = 1'b1;
        tick(2);
        chk("resume_k2_led", led_select, 8'h80);
        tick(1);
        chk("resume_led",  led_select, 8'h40);
        chk("resume_tick", step_tick,  1'b1);
        for (int i = 0; i < 8; i++) begin
            tick(5);
            chk($sformatf("rr_led%0d", i), led_select, rr_led[i]);
            chk($sformatf("rr_pos%0d", i), pos, rr_pos[i]);
        end
        chk("rr_done", done, 1'b0);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        chk("rr_stop_rdy",  cfg_ready,  1'b1);
        chk("rr_stop_busy", busy,       1'b0);
        chk("rr_stop_led",  led_select, 8'h40);

        // mode 3 blink, div 2; stop collides with a due step
        cfg(2'd3, 16'd2, 8'd0);
        chk("bl_start", led_select, 8'h00);
        tick(2);
        chk("bl_led", led_select, 8'hFF);
        chk("bl_pos", pos,        3'd0);
        tick(1);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        chk("bl_stop_led",  led_select, 8'hFF);
        chk("bl_stop_tick", step_tick,  1'b0);
        chk("bl_stop_done", done,       1'b0);
        chk("bl_stop_rdy",  cfg_ready,  1'b1);
        tick(1);
        chk("bl_stop_done2", done, 1'b0);

        // div 0 behaves as 1; config while busy is ignored
        cfg(2'd0, 16'd0, 8'd2);
        cfg_mode = 2'd1; cfg_div = 16'd9; cfg_steps = 8'd0; cfg_valid = 1'b1;
        tick(1);
        chk("d0_led1", led_select, 8'h02);
        chk("d0_tick", step_tick,  1'b1);
        tick(1);
        cfg_valid = 1'b0;
        chk("d0_led2", led_select, 8'h04);
        chk("d0_done", done,       1'b1);
        tick(1);
        chk("d0_rdy",  cfg_ready,  1'b1);
        chk("d0_led3", led_select, 8'h04);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
